// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the accumulator CPU bus.
// Provides single-cycle registered RAM read/write, two memory-mapped I/O
// locations (IN_PORT at depth-2, OUT_PORT at depth-1) and a program-load
// port that is serviced only on edges where the CPU bus is idle.
module mem_responder #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned ADDR_W = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              CS,
    input  logic              R_NW,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              wr_done,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ack,
    input  logic [WORD_W-1:0] in_port,
    output logic [WORD_W-1:0] out_port
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] OUT_ADDR = '1;
    localparam logic [ADDR_W-1:0] IN_ADDR  = {{(ADDR_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE,
        RD_RESP,
        WR_RESP,
        LD_RESP
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_rdata;
    logic [WORD_W-1:0] r_out_port;
    logic [WORD_W-1:0] r_in_sync1;
    logic [WORD_W-1:0] r_in_sync2;
    logic [WORD_W-1:0] r_mem [0:DEPTH-1];

    logic              w_cpu_rd;
    logic              w_cpu_wr;
    logic              w_load;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WORD_W-1:0] w_wr_data;
    logic [WORD_W-1:0] w_rd_word;

    // Access decode: CPU has priority, loads only take CS-free edges.
    always_comb begin
        w_cpu_rd  = CS & R_NW;
        w_cpu_wr  = CS & ~R_NW;
        w_load    = ~CS & ld_en;
        w_wr_en   = w_cpu_wr | w_load;
        w_wr_addr = CS ? address : ld_addr;
        w_wr_data = CS ? wdata : ld_data;
    end

    // Read mux over the address map: RAM, synchronised input, output latch.
    always_comb begin
        w_rd_word = r_mem[address];
        if (address == IN_ADDR) begin
            w_rd_word = r_in_sync2;
        end else if (address == OUT_ADDR) begin
            w_rd_word = r_out_port;
        end
    end

    // RAM array: no reset so contents survive n_reset; writes blocked while in reset.
    always_ff @(posedge clock) begin
        if (n_reset && w_wr_en && (w_wr_addr != IN_ADDR) && (w_wr_addr != OUT_ADDR)) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Two-flop synchroniser for the asynchronous input port.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_in_sync1 <= '0;
            r_in_sync2 <= '0;
        end else begin
            r_in_sync1 <= in_port;
            r_in_sync2 <= r_in_sync1;
        end
    end

    // Output port latch, written by CPU stores or loads to OUT_ADDR.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_out_port <= '0;
        end else if (w_wr_en && (w_wr_addr == OUT_ADDR)) begin
            r_out_port <= w_wr_data;
        end
    end

    // Response FSM: next state depends only on this edge's inputs; read data captured here.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
            r_rdata <= '0;
        end else begin
            if (w_cpu_rd) begin
                r_state <= RD_RESP;
                r_rdata <= w_rd_word;
            end else if (w_cpu_wr) begin
                r_state <= WR_RESP;
            end else if (w_load) begin
                r_state <= LD_RESP;
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign rdata       = r_rdata;
    assign out_port    = r_out_port;
    assign rdata_valid = (r_state == RD_RESP);
    assign wr_done     = (r_state == WR_RESP);
    assign ld_ack      = (r_state == LD_RESP);

endmodule
